// File: rtl/mux_mem_bram_responder.sv
// Block-RAM responder for the mux-to-memory request interface.
// It serves 8/16/32-bit reads and writes through four byte-lane RAMs.

module mux_mem_bram_lane #(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] ridx,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH_WORDS] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (we)
            mem[widx] <= wdata;
        rdata <= mem[ridx];
    end
endmodule

module mux_mem_bram_responder #(
    parameter int DEPTH_WORDS = 512,
    parameter int RD_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [25:0] mem_addr,
    input  logic [1:0]  mem_data_width,
    input  logic [31:0] mem_wr_data,
    output logic        mem_rd_ready,
    output logic        mem_wr_ready,
    output logic        mem_rd_valid,
    output logic [31:0] mem_rd_data,
    output logic        mem_err
);
    localparam int AW        = $clog2(DEPTH_WORDS);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, WR_BUSY, RD_WAIT, RD_DONE} state_t;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [1:0]    off;
        logic [1:0]    width;
    } rd_req_t;

    state_t  state;
    rd_req_t req;
    logic [3:0] cnt;
    logic       rdy;

    logic        wr_acc, rd_acc, width_bad;
    logic [AW-1:0] req_idx, rd_idx;
    logic [NUM_LANES-1:0]      lane_we;
    logic [NUM_LANES-1:0][7:0] wr_lanes;
    logic [NUM_LANES-1:0][7:0] rd_lanes;

    function automatic logic [3:0] lane_en(input logic [1:0] w, input logic [1:0] off);
        case (w)
            2'b01:   return 4'b0001 << off;
            2'b10:   return off[1] ? 4'b1100 : 4'b0011;
            2'b11:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b01:   return {4{d[7:0]}};
            2'b10:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Shift the selected lane(s) down to bit 0 and zero-extend.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] w,
                                            input logic [1:0] off);
        case (w)
            2'b01:   return {24'h0, word[{off, 3'b000} +: 8]};
            2'b10:   return off[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
            2'b11:   return word;
            default: return 32'h0;
        endcase
    endfunction

    assign mem_rd_ready = rdy;
    assign mem_wr_ready = rdy;

    // A write wins when both strobes are high; the read is dropped and flagged.
    assign wr_acc    = mem_wr & rdy;
    assign rd_acc    = mem_rd & rdy & ~mem_wr;
    assign width_bad = (mem_data_width == 2'b00);
    assign req_idx   = mem_addr[AW+1:2];

    assign lane_we  = wr_acc ? lane_en(mem_data_width, mem_addr[1:0]) : 4'b0000;
    assign wr_lanes = replicate(mem_data_width, mem_wr_data);
    assign rd_idx   = (state == IDLE) ? req_idx : req.idx;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mux_mem_bram_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .widx  (req_idx),
            .wdata (wr_lanes[i]),
            .ridx  (rd_idx),
            .rdata (rd_lanes[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rdy          <= 1'b0;
            cnt          <= 4'd0;
            req          <= '0;
            mem_rd_valid <= 1'b0;
            mem_rd_data  <= 32'h0;
            mem_err      <= 1'b0;
        end else begin
            mem_rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_acc) begin
                        state <= WR_BUSY;
                        rdy   <= 1'b0;
                        if (width_bad || mem_rd)
                            mem_err <= 1'b1;
                    end else if (rd_acc) begin
                        state     <= RD_WAIT;
                        rdy       <= 1'b0;
                        cnt       <= 4'(RD_LATENCY - 1);
                        req.idx   <= req_idx;
                        req.off   <= mem_addr[1:0];
                        req.width <= mem_data_width;
                        if (width_bad)
                            mem_err <= 1'b1;
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                WR_BUSY: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
                // The lane RAMs re-read the latched index every cycle here.
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= RD_DONE;
                        mem_rd_valid <= 1'b1;
                        mem_rd_data  <= extract(rd_lanes, req.width, req.off);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_DONE: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_mem_bram_responder.sv
// Directed bench for mux_mem_bram_responder: latency-2 instance for the main
// vectors, latency-5 instance for the reset-during-read sequence.

module tb_mux_mem_bram_responder;
    logic        clk = 1'b0;
    logic        rst, rst5;
    logic        mem_rd, mem_wr;
    logic [25:0] mem_addr;
    logic [1:0]  mem_data_width;
    logic [31:0] mem_wr_data;

    logic        rrdy2, wrdy2, vld2, err2, rrdy5, wrdy5, vld5, err5;
    logic [31:0] data2, data5;

    logic        sel;
    logic        cur_rdy, cur_vld, cur_err;
    logic [31:0] cur_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mux_mem_bram_responder #(.DEPTH_WORDS(512), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_width(mem_data_width), .mem_wr_data(mem_wr_data),
        .mem_rd_ready(rrdy2), .mem_wr_ready(wrdy2), .mem_rd_valid(vld2),
        .mem_rd_data(data2), .mem_err(err2));

    mux_mem_bram_responder #(.DEPTH_WORDS(512), .RD_LATENCY(5)) u_dut5 (
        .clk(clk), .rst(rst5), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_width(mem_data_width), .mem_wr_data(mem_wr_data),
        .mem_rd_ready(rrdy5), .mem_wr_ready(wrdy5), .mem_rd_valid(vld5),
        .mem_rd_data(data5), .mem_err(err5));

    assign cur_rdy  = sel ? (rrdy5 & wrdy5) : (rrdy2 & wrdy2);
    assign cur_vld  = sel ? vld5  : vld2;
    assign cur_err  = sel ? err5  : err2;
    assign cur_data = sel ? data5 : data2;

    typedef struct {
        logic        wr;
        logic [25:0] addr;
        logic [1:0]  width;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cur_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cur_rdy) check("ready_timeout", {31'h0, cur_rdy}, 32'h1);
    endtask

    task automatic do_write(input logic [25:0] a, input logic [1:0] w, input logic [31:0] d);
        mem_wr = 1'b1; mem_addr = a; mem_data_width = w; mem_wr_data = d;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        mem_wr = 1'b0;
    endtask

    // Issues a read with both strobes optional; returns data and edges to valid.
    task automatic do_read(input logic [25:0] a, input logic [1:0] w,
                           output logic [31:0] d, output int lat);
        mem_rd = 1'b1; mem_addr = a; mem_data_width = w;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        mem_rd = 1'b0;
        lat = 0;
        while (!cur_vld && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        d = cur_data;
        @(negedge clk);
        check("valid_one_cycle", {31'h0, cur_vld}, 32'h0);
    endtask

    vec_t vecs[16];
    logic [31:0] rd;
    int          lat;
    int          nvld;

    initial begin
        vecs[0]  = '{1'b1, 26'h000, 2'b11, 32'h0123ABCD};
        vecs[1]  = '{1'b0, 26'h000, 2'b11, 32'h0123ABCD};
        vecs[2]  = '{1'b1, 26'h010, 2'b11, 32'hAABBCCDD};
        vecs[3]  = '{1'b1, 26'h012, 2'b01, 32'h00000055};
        vecs[4]  = '{1'b0, 26'h010, 2'b01, 32'h000000DD};
        vecs[5]  = '{1'b0, 26'h011, 2'b01, 32'h000000CC};
        vecs[6]  = '{1'b0, 26'h012, 2'b01, 32'h00000055};
        vecs[7]  = '{1'b0, 26'h013, 2'b01, 32'h000000AA};
        vecs[8]  = '{1'b0, 26'h010, 2'b11, 32'hAA55CCDD};
        vecs[9]  = '{1'b1, 26'h022, 2'b10, 32'h0000BEEF};
        vecs[10] = '{1'b0, 26'h023, 2'b10, 32'h0000BEEF};
        vecs[11] = '{1'b0, 26'h020, 2'b11, 32'hBEEF0000};
        vecs[12] = '{1'b1, 26'h031, 2'b01, 32'h00009A7E};
        vecs[13] = '{1'b0, 26'h030, 2'b11, 32'h00007E00};
        vecs[14] = '{1'b1, 26'h800, 2'b11, 32'h12345678};
        vecs[15] = '{1'b0, 26'h000, 2'b11, 32'h12345678};

        sel = 1'b0;
        rst = 1'b1; rst5 = 1'b1;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_data_width = 2'b11; mem_wr_data = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'h0, cur_rdy}, 32'h0);
        check("reset_valid", {31'h0, cur_vld}, 32'h0);
        check("reset_data",  cur_data, 32'h0);
        check("reset_err",   {31'h0, cur_err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", {31'h0, cur_rdy}, 32'h1);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].width, vecs[i].data);
            end else begin
                do_read(vecs[i].addr, vecs[i].width, rd, lat);
                check($sformatf("vec%0d_data", i), rd, vecs[i].data);
                check($sformatf("vec%0d_latency", i), lat, 2);
                check($sformatf("vec%0d_err", i), {31'h0, cur_err}, 32'h0);
            end
        end

        // Ready drops for exactly one cycle after a write.
        mem_wr = 1'b1; mem_addr = 26'h40; mem_data_width = 2'b11; mem_wr_data = 32'h11112222;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        mem_wr = 1'b0;
        check("wr_busy_ready_low", {31'h0, cur_rdy}, 32'h0);
        @(negedge clk);
        check("wr_ready_back", {31'h0, cur_rdy}, 32'h1);

        // Both strobes: write served, read dropped, error set.
        mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 26'h4; mem_data_width = 2'b11;
        mem_wr_data = 32'hCAFEF00D;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0;
        nvld = 0;
        for (int k = 0; k < 6; k++) begin
            if (cur_vld) nvld++;
            @(negedge clk);
        end
        check("collision_no_valid", nvld, 0);
        check("collision_err", {31'h0, cur_err}, 32'h1);
        do_read(26'h4, 2'b11, rd, lat);
        check("collision_write_data", rd, 32'hCAFEF00D);

        // Width 00: write ignored, read returns zero, error stays set.
        do_write(26'h4, 2'b00, 32'h0);
        do_read(26'h4, 2'b00, rd, lat);
        check("width00_read_zero", rd, 32'h0);
        check("width00_err", {31'h0, cur_err}, 32'h1);
        do_read(26'h4, 2'b11, rd, lat);
        check("width00_no_write", rd, 32'hCAFEF00D);
        check("err_sticky", {31'h0, cur_err}, 32'h1);

        // Latency-5 instance: reset two cycles into a read.
        sel = 1'b1;
        rst5 = 1'b0;
        repeat (2) @(negedge clk);
        check("l5_err_clear", {31'h0, cur_err}, 32'h0);
        do_write(26'h40, 2'b11, 32'hDEADBEEF);
        do_read(26'h40, 2'b11, rd, lat);
        check("l5_data", rd, 32'hDEADBEEF);
        check("l5_latency", lat, 5);

        mem_rd = 1'b1; mem_addr = 26'h40; mem_data_width = 2'b11;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        mem_rd = 1'b0;
        nvld = 0;
        @(negedge clk);
        rst5 = 1'b1;
        @(negedge clk);
        check("l5_reset_ready_low", {31'h0, cur_rdy}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            if (cur_vld) nvld++;
            @(negedge clk);
        end
        check("l5_reset_no_valid", nvld, 0);
        check("l5_reset_ready_held", {31'h0, cur_rdy}, 32'h0);
        rst5 = 1'b0;
        @(negedge clk);
        check("l5_ready_after_release", {31'h0, cur_rdy}, 32'h1);
        do_read(26'h40, 2'b11, rd, lat);
        check("l5_data_preserved", rd, 32'hDEADBEEF);
        check("l5_latency_after_reset", lat, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
